// File: rtl/sram_port_arbiter.sv
// Two-master sram-like port arbiter: round-robin grant locked until addr handshake, in-order response routing.
// Latency: 0 cycles on request and response paths; only the order bookkeeping is registered.
// Backpressure: s_req withheld while OUTS requests are outstanding; masters hold req until their addr_ok.
module sram_port_arbiter #(
    parameter int OUTS  = 4,
    parameter int CNT_W = 3
) (
    input  logic             aclk,
    input  logic             areset,

    input  logic             m0_req,
    input  logic             m0_wr,
    input  logic [1:0]       m0_size,
    input  logic [31:0]      m0_addr,
    input  logic [3:0]       m0_wstrb,
    input  logic [31:0]      m0_wdata,
    output logic             m0_addr_ok,
    output logic             m0_data_ok,
    output logic [31:0]      m0_rdata,

    input  logic             m1_req,
    input  logic             m1_wr,
    input  logic [1:0]       m1_size,
    input  logic [31:0]      m1_addr,
    input  logic [3:0]       m1_wstrb,
    input  logic [31:0]      m1_wdata,
    output logic             m1_addr_ok,
    output logic             m1_data_ok,
    output logic [31:0]      m1_rdata,

    output logic             s_req,
    output logic             s_wr,
    output logic [1:0]       s_size,
    output logic [31:0]      s_addr,
    output logic [3:0]       s_wstrb,
    output logic [31:0]      s_wdata,
    input  logic             s_addr_ok,
    input  logic             s_data_ok,
    input  logic [31:0]      s_rdata,

    output logic [CNT_W-1:0] outstanding,
    output logic             proto_err
);

    localparam int PTR_W = (OUTS > 1) ? $clog2(OUTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             rr_pref;      // master that wins the next tie
    logic [OUTS-1:0]  ord_mem;      // master id of each accepted, unanswered request
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             proto_err_r;

    logic             full;
    logic             empty;
    logic             grant_vld;
    logic             grant_id;
    logic             gnt_req;
    logic             s_req_i;
    logic             hs;
    logic             pop;
    logic             head_id;

    assign full    = (count == CNT_W'(OUTS));
    assign empty   = (count == '0);
    assign head_id = ord_mem[rd_ptr];

    // Grant selection and lock state machine; a lock pins the grant until the address handshake.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        state_nxt = state;
        case (state)
            ST_LOCK0: begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end
            ST_LOCK1: begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
            default: begin
                if (!full) begin
                    if (m0_req && m1_req) begin
                        grant_vld = 1'b1;
                        grant_id  = rr_pref;
                    end else if (m0_req) begin
                        grant_vld = 1'b1;
                        grant_id  = 1'b0;
                    end else if (m1_req) begin
                        grant_vld = 1'b1;
                        grant_id  = 1'b1;
                    end
                end
            end
        endcase
        // Everything facing the masters and the bridge is quiet while reset is asserted.
        if (areset) begin
            grant_vld = 1'b0;
        end
        gnt_req = grant_id ? m1_req : m0_req;
        s_req_i = grant_vld && gnt_req && !full;
        hs      = s_req_i && s_addr_ok;
        case (state)
            ST_IDLE: begin
                if (s_req_i && !s_addr_ok) begin
                    state_nxt = grant_id ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (hs || !gnt_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lock state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer moves to the other master after each accepted request.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_pref <= 1'b0;
        end else if (hs) begin
            rr_pref <= ~grant_id;
        end
    end

    assign pop = s_data_ok && !empty && !areset;

    // Order FIFO: push the granted id on acceptance, pop the head on each response; pointers wrap modulo OUTS.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ord_mem <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (hs) begin
                ord_mem[wr_ptr] <= grant_id;
                wr_ptr <= (wr_ptr == PTR_W'(OUTS - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(OUTS - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (hs && !pop) begin
                count <= count + 1'b1;
            end else if (!hs && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky flag for a bridge response that has no matching accepted request.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            proto_err_r <= 1'b0;
        end else if (s_data_ok && empty) begin
            proto_err_r <= 1'b1;
        end
    end

    assign s_req      = s_req_i;
    assign s_wr       = grant_vld ? (grant_id ? m1_wr    : m0_wr)    : 1'b0;
    assign s_size     = grant_vld ? (grant_id ? m1_size  : m0_size)  : 2'd0;
    assign s_addr     = grant_vld ? (grant_id ? m1_addr  : m0_addr)  : 32'd0;
    assign s_wstrb    = grant_vld ? (grant_id ? m1_wstrb : m0_wstrb) : 4'd0;
    assign s_wdata    = grant_vld ? (grant_id ? m1_wdata : m0_wdata) : 32'd0;

    assign m0_addr_ok = hs && !grant_id;
    assign m1_addr_ok = hs &&  grant_id;

    // The head is read before this cycle's push lands, so a fresh request is never answered the same cycle.
    assign m0_data_ok = pop && !head_id;
    assign m1_data_ok = pop &&  head_id;
    assign m0_rdata   = m0_data_ok ? s_rdata : 32'd0;
    assign m1_rdata   = m1_data_ok ? s_rdata : 32'd0;

    assign outstanding = count;
    assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Bridge and masters are modelled by the bench; masters hold req until addr_ok.
module tb_sram_port_arbiter;

    localparam int OUTS  = 4;
    localparam int CNT_W = 3;

    logic             aclk;
    logic             areset;
    logic             m0_req, m0_wr, m0_addr_ok, m0_data_ok;
    logic [1:0]       m0_size;
    logic [31:0]      m0_addr, m0_wdata, m0_rdata;
    logic [3:0]       m0_wstrb;
    logic             m1_req, m1_wr, m1_addr_ok, m1_data_ok;
    logic [1:0]       m1_size;
    logic [31:0]      m1_addr, m1_wdata, m1_rdata;
    logic [3:0]       m1_wstrb;
    logic             s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]       s_size;
    logic [31:0]      s_addr, s_wdata, s_rdata;
    logic [3:0]       s_wstrb;
    logic [CNT_W-1:0] outstanding;
    logic             proto_err;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.OUTS(OUTS), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .areset(areset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic clear_inputs();
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wstrb = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wstrb = 0; m1_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        logic [143:0] got;
        areset = 1'b1;
        clear_inputs();
        m0_req = 1; m1_req = 1; m0_addr = 32'h55; m1_addr = 32'h66; m0_wdata = 32'h77;
        s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'hFFFF_FFFF;
        @(negedge aclk);
        got = {s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata, m0_addr_ok, m0_data_ok, m0_rdata,
               m1_addr_ok, m1_data_ok, m1_rdata, outstanding, proto_err};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        apply_reset();
        step();
        m0_req = 1; m0_wr = 0; m0_size = 2; m0_addr = 32'h1000;
        @(negedge aclk);
        total++;
        if ({s_req, s_addr, m0_addr_ok} !== {1'b1, 32'h1000, 1'b0}) begin
            bad++;
            $display("FAIL single_req got=%h exp=%h", {s_req, s_addr, m0_addr_ok}, {1'b1, 32'h1000, 1'b0});
        end
        step();
        s_addr_ok = 1;
        @(negedge aclk);
        total++;
        if ({m0_addr_ok, m1_addr_ok} !== 2'b10) begin
            bad++;
            $display("FAIL single_addr_ok got=%b exp=10", {m0_addr_ok, m1_addr_ok});
        end
        step();
        m0_req = 0; s_addr_ok = 0;
        @(negedge aclk);
        total++;
        if ({s_req, outstanding} !== {1'b0, 3'd1}) begin
            bad++;
            $display("FAIL single_outstanding got=%h exp=%h", {s_req, outstanding}, {1'b0, 3'd1});
        end
        step();
        s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        @(negedge aclk);
        total++;
        if ({m0_data_ok, m1_data_ok, m0_rdata, m1_rdata} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
            bad++;
            $display("FAIL single_resp got=%h exp=%h", {m0_data_ok, m1_data_ok, m0_rdata, m1_rdata},
                     {2'b10, 32'hDEADBEEF, 32'h0});
        end
        step();
        s_data_ok = 0; s_rdata = 0;
        @(negedge aclk);
        total++;
        if (outstanding !== 3'd0) begin
            bad++;
            $display("FAIL single_drain got=%0d exp=0", outstanding);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] ea;
        logic [31:0] er;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            m0_req = 1; m1_req = 1; m0_addr = 32'hA0; m1_addr = 32'hB0; s_addr_ok = 1;
            @(negedge aclk);
            ea = (i % 2 == 1) ? 32'hB0 : 32'hA0;
            total++;
            if ({s_addr, m0_addr_ok, m1_addr_ok} !== {ea, (i % 2 == 0), (i % 2 == 1)}) begin
                bad++;
                $display("FAIL rr_grant%0d got=%h exp=%h", i, {s_addr, m0_addr_ok, m1_addr_ok},
                         {ea, (i % 2 == 0), (i % 2 == 1)});
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            m0_req = 0; m1_req = 0; s_addr_ok = 0;
            s_data_ok = 1; s_rdata = 32'h11 * (i + 1);
            @(negedge aclk);
            er = 32'h11 * (i + 1);
            total++;
            if ({m0_data_ok, m1_data_ok, m0_rdata, m1_rdata} !==
                {(i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? er : 32'h0, (i % 2 == 1) ? er : 32'h0}) begin
                bad++;
                $display("FAIL rr_resp%0d got=%h", i, {m0_data_ok, m1_data_ok, m0_rdata, m1_rdata});
            end
        end
        step();
        s_data_ok = 0;
    endtask

    task automatic test_lock();
        apply_reset();
        step();
        m1_req = 1; m1_addr = 32'h2000; m0_addr = 32'h3000;
        @(negedge aclk);
        total++;
        if ({s_req, s_addr} !== {1'b1, 32'h2000}) begin
            bad++;
            $display("FAIL lock_first got=%h exp=%h", {s_req, s_addr}, {1'b1, 32'h2000});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            m0_req = 1;
            @(negedge aclk);
            total++;
            if ({s_req, s_addr, m0_addr_ok} !== {1'b1, 32'h2000, 1'b0}) begin
                bad++;
                $display("FAIL lock_hold%0d got=%h exp=%h", i, {s_req, s_addr, m0_addr_ok},
                         {1'b1, 32'h2000, 1'b0});
            end
        end
        step();
        s_addr_ok = 1;
        @(negedge aclk);
        total++;
        if ({s_addr, m0_addr_ok, m1_addr_ok} !== {32'h2000, 2'b01}) begin
            bad++;
            $display("FAIL lock_accept got=%h exp=%h", {s_addr, m0_addr_ok, m1_addr_ok}, {32'h2000, 2'b01});
        end
        step();
        m1_req = 0; s_addr_ok = 0;
        @(negedge aclk);
        total++;
        if ({s_req, s_addr} !== {1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL lock_next got=%h exp=%h", {s_req, s_addr}, {1'b1, 32'h3000});
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            m0_req = 1; m1_req = 1; s_addr_ok = 1;
        end
        step();
        s_addr_ok = 0;
        @(negedge aclk);
        total++;
        if ({outstanding, s_req, m0_addr_ok, m1_addr_ok} !== {3'd4, 3'b000}) begin
            bad++;
            $display("FAIL full_block got=%h exp=%h", {outstanding, s_req, m0_addr_ok, m1_addr_ok}, {3'd4, 3'b000});
        end
        step();
        s_data_ok = 1; s_rdata = 32'h99;
        @(negedge aclk);
        total++;
        if ({m0_data_ok, m1_data_ok, s_req} !== 3'b100) begin
            bad++;
            $display("FAIL full_pop got=%b exp=100", {m0_data_ok, m1_data_ok, s_req});
        end
        step();
        s_data_ok = 0;
        @(negedge aclk);
        total++;
        if ({outstanding, s_req} !== {3'd3, 1'b1}) begin
            bad++;
            $display("FAIL full_release got=%h exp=%h", {outstanding, s_req}, {3'd3, 1'b1});
        end
    endtask

    task automatic test_back_to_back_wrap();
        bit eq[$];
        bit nx;
        bit h;
        logic [31:0] er;
        apply_reset();
        step();
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        step();
        eq.push_back(1'b0);
        eq.push_back(1'b1);
        nx = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            s_data_ok = 1; s_rdata = 32'h100 + k;
            @(negedge aclk);
            h  = eq.pop_front();
            er = 32'h100 + k;
            eq.push_back(nx);
            nx = ~nx;
            total++;
            if ({outstanding, m0_data_ok, m1_data_ok} !== {3'd2, ~h, h}) begin
                bad++;
                $display("FAIL wrap_route%0d got=%h exp=%h", k, {outstanding, m0_data_ok, m1_data_ok}, {3'd2, ~h, h});
            end
            total++;
            if ((h ? m1_rdata : m0_rdata) !== er) begin
                bad++;
                $display("FAIL wrap_rdata%0d got=%h exp=%h", k, (h ? m1_rdata : m0_rdata), er);
            end
        end
        step();
        clear_inputs();
        @(negedge aclk);
        total++;
        if (outstanding !== 3'd2) begin
            bad++;
            $display("FAIL wrap_count got=%0d exp=2", outstanding);
        end
    endtask

    task automatic test_proto_and_reset();
        logic [143:0] got;
        apply_reset();
        step();
        s_data_ok = 1; s_rdata = 32'h1234;
        @(negedge aclk);
        total++;
        if ({m0_data_ok, m1_data_ok, m0_rdata, m1_rdata} !== '0) begin
            bad++;
            $display("FAIL proto_nodok got=%h exp=0", {m0_data_ok, m1_data_ok, m0_rdata, m1_rdata});
        end
        step();
        s_data_ok = 0;
        repeat (3) begin
            @(negedge aclk);
            total++;
            if (proto_err !== 1'b1) begin
                bad++;
                $display("FAIL proto_sticky got=%b exp=1", proto_err);
            end
            step();
        end
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        step();
        step();
        @(negedge aclk);
        total++;
        if (outstanding !== 3'd2) begin
            bad++;
            $display("FAIL burst_count got=%0d exp=2", outstanding);
        end
        step();
        areset = 1'b1;
        s_data_ok = 1; s_rdata = 32'hCAFE;
        @(negedge aclk);
        got = {s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata, m0_addr_ok, m0_data_ok, m0_rdata,
               m1_addr_ok, m1_data_ok, m1_rdata, outstanding, proto_err};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h exp=0", got);
        end
        clear_inputs();
        areset = 1'b0;
        step();
        @(negedge aclk);
        total++;
        if ({outstanding, proto_err} !== 4'b0) begin
            bad++;
            $display("FAIL midreset_after got=%h exp=0", {outstanding, proto_err});
        end
    endtask

    task automatic test_random(input int n);
        bit          q[$];
        bit          rr, pend_vld, pend_id, perr;
        bit          acc [2];
        logic        r_req [2];
        logic        r_wr [2];
        logic [1:0]  r_size [2];
        logic [31:0] r_addr [2];
        logic [3:0]  r_wstrb [2];
        logic [31:0] r_wdata [2];
        bit          full, gv, g, e_sreq, hs, resp, h;
        logic [5:0]  e_flags;
        logic [68:0] e_pay;
        logic [31:0] e_rd [2];
        apply_reset();
        rr = 0; pend_vld = 0; pend_id = 0; perr = 0;
        for (int m = 0; m < 2; m++) begin
            acc[m] = 0; r_req[m] = 0; r_wr[m] = 0; r_size[m] = 0;
            r_addr[m] = 0; r_wstrb[m] = 0; r_wdata[m] = 0;
        end
        for (int c = 0; c < n; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (!r_req[m] || acc[m]) begin
                    r_req[m]   = ($urandom_range(0, 2) != 0);
                    r_wr[m]    = 1'($urandom);
                    r_size[m]  = 2'($urandom);
                    r_addr[m]  = $urandom;
                    r_wstrb[m] = 4'($urandom);
                    r_wdata[m] = $urandom;
                end
            end
            m0_req = r_req[0]; m0_wr = r_wr[0]; m0_size = r_size[0];
            m0_addr = r_addr[0]; m0_wstrb = r_wstrb[0]; m0_wdata = r_wdata[0];
            m1_req = r_req[1]; m1_wr = r_wr[1]; m1_size = r_size[1];
            m1_addr = r_addr[1]; m1_wstrb = r_wstrb[1]; m1_wdata = r_wdata[1];
            s_addr_ok = (q.size() < OUTS) && ($urandom_range(0, 1) == 1);
            if (q.size() != 0) s_data_ok = ($urandom_range(0, 9) < 4);
            else               s_data_ok = ($urandom_range(0, 29) == 0);
            s_rdata = $urandom;
            @(negedge aclk);

            full = (q.size() == OUTS);
            gv = 0; g = 0;
            if (pend_vld) begin
                gv = 1; g = pend_id;
            end else if (!full) begin
                if (r_req[0] && r_req[1]) begin gv = 1; g = rr; end
                else if (r_req[0])        begin gv = 1; g = 0;  end
                else if (r_req[1])        begin gv = 1; g = 1;  end
            end
            e_sreq = gv && r_req[g] && !full;
            hs     = e_sreq && s_addr_ok;
            resp   = s_data_ok && (q.size() != 0);
            h      = resp ? q[0] : 1'b0;
            e_pay  = gv ? {r_wr[g], r_size[g], r_addr[g], r_wstrb[g], r_wdata[g][31:2]} : '0;
            e_flags = {e_sreq, hs && !g, hs && g, resp && !h, resp && h, perr};
            e_rd[0] = (resp && !h) ? s_rdata : 32'h0;
            e_rd[1] = (resp &&  h) ? s_rdata : 32'h0;

            total++;
            if ({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, proto_err} !== e_flags) begin
                bad++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c,
                         {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, proto_err}, e_flags);
            end
            total++;
            if ({s_wr, s_size, s_addr, s_wstrb, s_wdata[31:2]} !== e_pay) begin
                bad++;
                $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", c,
                         {s_wr, s_size, s_addr, s_wstrb, s_wdata[31:2]}, e_pay);
            end
            total++;
            if ({m0_rdata, m1_rdata} !== {e_rd[0], e_rd[1]}) begin
                bad++;
                $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, {m0_rdata, m1_rdata}, {e_rd[0], e_rd[1]});
            end
            total++;
            if (outstanding !== CNT_W'(q.size())) begin
                bad++;
                $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", c, outstanding, q.size());
            end

            if (resp) void'(q.pop_front());
            else if (s_data_ok) perr = 1;
            if (hs) begin
                q.push_back(g);
                rr = ~g;
                pend_vld = 0;
            end else if (e_sreq) begin
                pend_vld = 1;
                pend_id  = g;
            end
            acc[0] = hs && !g;
            acc[1] = hs && g;
        end
        step();
        clear_inputs();
    endtask

    initial begin
        areset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_full();
        test_back_to_back_wrap();
        test_proto_and_reset();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
